// File: rtl/adc_oversampler_if.sv
// adc_oversampler_if
//   Groups the conversion input bus, control inputs and averaged output
//   bus of the oversampling averager.
//   master : side that drives conversions/control and consumes results
//   slave  : the averager itself
//   Signals: en, clear, osr_log2[2:0], data_valid, din[119:0]  (master -> slave)
//            dout[119:0], dout_valid, busy, overrun          (slave -> master)
interface adc_oversampler_if;
  logic         en;
  logic         clear;
  logic [2:0]   osr_log2;
  logic         data_valid;
  logic [119:0] din;
  logic [119:0] dout;
  logic         dout_valid;
  logic         busy;
  logic         overrun;

  modport master (
    output en, clear, osr_log2, data_valid, din,
    input  dout, dout_valid, busy, overrun
  );

  modport slave (
    input  en, clear, osr_log2, data_valid, din,
    output dout, dout_valid, busy, overrun
  );
endinterface

// File: rtl/adc_oversampler.sv
// adc_oversampler
//   Per-channel oversampling averager for the 8-channel ADC driver. Each
//   rising edge of data_valid snapshots eight 15-bit two's complement words;
//   2^osr_q conversions are summed per channel through one shared adder
//   (one channel per cycle) and the averages are published with a one-cycle
//   dout_valid pulse.
//   Ports:
//     clk        system clock
//     rst_n      asynchronous active-low reset
//     bus        adc_oversampler_if.slave (en, clear, osr_log2, data_valid,
//                din in; dout, dout_valid, busy, overrun out)
//   Parameter:
//     OSR_MAX_LOG2  maximum log2 oversampling ratio (osr_log2 is clamped to it)
//   Build option:
//     ADC_OVS_ROUND_EN  when defined, results are rounded half up instead of
//                       truncated toward minus infinity.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | waiting for a conversion edge
//   ACC   | adding the 8 snapshotted samples, one channel per cycle
//   OUT   | window complete, averages loaded into dout on exit
module adc_oversampler #(
  parameter int OSR_MAX_LOG2 = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  adc_oversampler_if.slave bus
);

  localparam int         ACC_W   = 15 + OSR_MAX_LOG2 + 1;
  localparam int         CNT_W   = OSR_MAX_LOG2 + 1;
  localparam logic [2:0] OSR_CAP = 3'(OSR_MAX_LOG2);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t state, next_state;

  logic                    dv_q;
  logic                    conv_evt;
  logic [14:0]             sample [8];
  logic signed [ACC_W-1:0] acc [8];
  logic [2:0]              ch_idx;
  logic [2:0]              osr_q;
  logic [2:0]              osr_clamped;
  logic [CNT_W-1:0]        count;
  logic [CNT_W-1:0]        count_inc;
  logic [CNT_W-1:0]        target;
  logic                    win_done;
  logic signed [ACC_W-1:0] acc_base;
  logic signed [ACC_W-1:0] sum;

  logic signed [ACC_W-1:0] pre_shift [8];
  logic signed [ACC_W-1:0] shifted [8];
  logic [14:0]             avg [8];
  logic [7:0]              unused_hi;

  logic snap_en, osr_load, acc_we, last_ch, out_load, ovr_set, busy_d;

  logic [119:0] dout_q;
  logic         dout_valid_q;
  logic         busy_q;
  logic         overrun_q;

  assign conv_evt    = bus.data_valid & ~dv_q;
  assign osr_clamped = (bus.osr_log2 > OSR_CAP) ? OSR_CAP : bus.osr_log2;
  assign count_inc   = count + CNT_W'(1);
  assign target      = CNT_W'(1) << osr_q;
  assign win_done    = (count_inc == target);

  // First sample of a window overwrites, so stale sums from an aborted
  // window never need an explicit wipe.
  assign acc_base = (count == '0) ? '0 : acc[ch_idx];
  assign sum      = acc_base + {{(ACC_W-15){sample[ch_idx][14]}}, sample[ch_idx]};

`ifdef ADC_OVS_ROUND_EN
  logic signed [ACC_W-1:0] round_add;
  assign round_add = (osr_q == 3'd0) ? '0 : (ACC_W'(1) << (osr_q - 3'd1));
`endif

  // The average of in-range samples always fits 15 bits, so the high bits
  // of the shifted sum are just sign copies and are dropped.
  always_comb begin
    for (int k = 0; k < 8; k++) begin
`ifdef ADC_OVS_ROUND_EN
      pre_shift[k] = acc[k] + round_add;
`else
      pre_shift[k] = acc[k];
`endif
      shifted[k]   = pre_shift[k] >>> osr_q;
      avg[k]       = shifted[k][14:0];
      unused_hi[k] = ^shifted[k][ACC_W-1:15];
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE: if (conv_evt && bus.en) next_state = S_ACC;
      S_ACC:  if (ch_idx == 3'd7)     next_state = win_done ? S_OUT : S_IDLE;
      S_OUT:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
    if (bus.clear) next_state = S_IDLE;
  end

  // Output / control decode
  always_comb begin
    snap_en  = 1'b0;
    osr_load = 1'b0;
    acc_we   = 1'b0;
    last_ch  = 1'b0;
    out_load = 1'b0;
    ovr_set  = 1'b0;
    busy_d   = (next_state != S_IDLE);
    if (!bus.clear) begin
      unique case (state)
        S_IDLE: begin
          snap_en  = conv_evt && bus.en;
          osr_load = conv_evt && bus.en && (count == '0);
        end
        S_ACC: begin
          acc_we  = 1'b1;
          last_ch = (ch_idx == 3'd7);
          ovr_set = conv_evt;
        end
        S_OUT: begin
          out_load = 1'b1;
          ovr_set  = conv_evt;
        end
        default: ;
      endcase
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dv_q         <= 1'b0;
      ch_idx       <= '0;
      osr_q        <= '0;
      count        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
      for (int k = 0; k < 8; k++) begin
        sample[k] <= '0;
        acc[k]    <= '0;
      end
    end else begin
      dv_q         <= bus.data_valid;
      busy_q       <= busy_d;
      dout_valid_q <= out_load;

      if (snap_en) begin
        for (int k = 0; k < 8; k++) sample[k] <= bus.din[15*k +: 15];
      end

      if (osr_load) osr_q <= osr_clamped;

      if (bus.clear || snap_en) ch_idx <= '0;
      else if (acc_we)          ch_idx <= ch_idx + 3'd1;

      if (bus.clear)    count <= '0;
      else if (last_ch) count <= win_done ? '0 : count_inc;

      if (acc_we) acc[ch_idx] <= sum;

      if (bus.clear)    overrun_q <= 1'b0;
      else if (ovr_set) overrun_q <= 1'b1;

      if (out_load) begin
        for (int k = 0; k < 8; k++) dout_q[15*k +: 15] <= avg[k];
      end
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.busy       = busy_q;
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_adc_oversampler.sv
// tb_adc_oversampler
//   Directed/randomized bench for adc_oversampler. Expected averages come
//   from per-channel integer sums divided by 2^n with floor semantics
//   (optionally rounded half up when ADC_OVS_ROUND_EN is defined).
module tb_adc_oversampler;

  logic clk;
  logic rst_n;
  adc_oversampler_if bus ();

  adc_oversampler #(.OSR_MAX_LOG2(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int sums [8];
  int npulse, pulse_at, busy_bad, stray;

  task automatic chk(input string tag, input logic [119:0] obs, input logic [119:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [119:0] rand_din();
    logic [119:0] r;
    for (int k = 0; k < 8; k++) r[15*k +: 15] = 15'($urandom);
    return r;
  endfunction

  function automatic logic [119:0] fill(input logic [14:0] v);
    logic [119:0] r;
    for (int k = 0; k < 8; k++) r[15*k +: 15] = v;
    return r;
  endfunction

  task automatic clear_sums();
    for (int k = 0; k < 8; k++) sums[k] = 0;
  endtask

  task automatic add_sample(input logic [119:0] d);
    for (int k = 0; k < 8; k++) sums[k] += int'($signed(d[15*k +: 15]));
  endtask

  function automatic logic [119:0] ref_out(input int n);
    logic [119:0] r;
    int s, dvs, q;
    dvs = 1 << n;
    for (int k = 0; k < 8; k++) begin
      s = sums[k];
`ifdef ADC_OVS_ROUND_EN
      if (n > 0) s = s + dvs / 2;
`endif
      q = s / dvs;
      if ((s % dvs) != 0 && s < 0) q = q - 1;
      r[15*k +: 15] = 15'(q);
    end
    return r;
  endfunction

  // One isolated conversion; records dout_valid pulses and busy behaviour.
  // fin says whether this sample completes a window.
  task automatic conv(input logic [119:0] d, input bit fin);
    @(negedge clk);
    bus.din        = d;
    bus.data_valid = 1'b1;
    @(posedge clk);
    npulse   = 0;
    pulse_at = 0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i == 2) bus.data_valid = 1'b0;
      if (bus.dout_valid) begin
        npulse++;
        if (pulse_at == 0) pulse_at = i;
      end
      if (bus.busy !== ((i <= 7) || (fin && i == 8))) busy_bad++;
    end
    if (!fin) stray += npulse;
  endtask

  logic [119:0] d, d1, d2, exp_v;
  int n, neff;

  initial begin
    busy_bad       = 0;
    stray          = 0;
    rst_n          = 1'b0;
    bus.en         = 1'b1;
    bus.clear      = 1'b0;
    bus.osr_log2   = 3'd0;
    bus.data_valid = 1'b0;
    bus.din        = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_dout", bus.dout, '0);
    chk("rst_dout_valid", bus.dout_valid, '0);
    chk("rst_busy", bus.busy, '0);
    chk("rst_overrun", bus.overrun, '0);
    rst_n = 1'b1;

    // osr 0: single conversion, ch0=100, ch7=-5
    bus.osr_log2 = 3'd0;
    d = rand_din();
    d[14:0]    = 15'd100;
    d[119:105] = 15'h7FFB;
    clear_sums(); add_sample(d);
    conv(d, 1'b1);
    chk("osr0_ch0", bus.dout[14:0], 15'd100);
    chk("osr0_ch7", bus.dout[119:105], 15'h7FFB);
    chk("osr0_dout", bus.dout, ref_out(0));
    chk("osr0_npulse", npulse, 1);
    chk("osr0_latency", pulse_at, 9);

    // osr 2: ch3 = 10, 11, 12, 14
    bus.osr_log2 = 3'd2;
    clear_sums();
    stray = 0;
    for (int j = 0; j < 4; j++) begin
      d = rand_din();
      d[59:45] = (j == 0) ? 15'd10 : (j == 1) ? 15'd11 : (j == 2) ? 15'd12 : 15'd14;
      add_sample(d);
      conv(d, j == 3);
    end
    chk("osr2_early_pulses", stray, 0);
    chk("osr2_ch3", bus.dout[59:45], 15'd11);
    chk("osr2_dout", bus.dout, ref_out(2));
    chk("osr2_latency", pulse_at, 9);

    // osr 1: ch1 = -1, -2
    bus.osr_log2 = 3'd1;
    clear_sums();
    d = rand_din(); d[29:15] = 15'h7FFF; add_sample(d); conv(d, 1'b0);
    d = rand_din(); d[29:15] = 15'h7FFE; add_sample(d); conv(d, 1'b1);
`ifdef ADC_OVS_ROUND_EN
    chk("osr1_ch1", bus.dout[29:15], 15'h7FFF);
`else
    chk("osr1_ch1", bus.dout[29:15], 15'h7FFE);
`endif
    chk("osr1_dout", bus.dout, ref_out(1));

    // osr 4 extremes
    bus.osr_log2 = 3'd4;
    for (int j = 0; j < 16; j++) conv(fill(15'h3FFF), j == 15);
    chk("osr4_max", bus.dout, fill(15'h3FFF));
    for (int j = 0; j < 16; j++) conv(fill(15'h4000), j == 15);
    chk("osr4_min", bus.dout, fill(15'h4000));
    chk("osr4_npulse", npulse, 1);

    // randomized windows, including clamped ratios
    for (int r = 0; r < 4; r++) begin
      n = (r == 0) ? 7 : int'($urandom_range(0, 7));
      neff = (n > 4) ? 4 : n;
      bus.osr_log2 = 3'(n);
      clear_sums();
      stray = 0;
      for (int j = 0; j < (1 << neff); j++) begin
        d = rand_din(); add_sample(d); conv(d, j == (1 << neff) - 1);
      end
      chk($sformatf("rand%0d_osr%0d_dout", r, n), bus.dout, ref_out(neff));
      chk($sformatf("rand%0d_stray", r), stray, 0);
    end

    // osr change mid-window applies only to the next window
    bus.osr_log2 = 3'd1;
    clear_sums();
    d = rand_din(); add_sample(d); conv(d, 1'b0);
    bus.osr_log2 = 3'd0;
    d = rand_din(); add_sample(d); conv(d, 1'b1);
    chk("osr_mid_change", bus.dout, ref_out(1));
    clear_sums();
    d = rand_din(); add_sample(d); conv(d, 1'b1);
    chk("osr_next_window", bus.dout, ref_out(0));

    // overrun: second edge 5 clk after P0 is dropped
    bus.osr_log2 = 3'd0;
    clear_sums();
    d1 = rand_din(); d2 = rand_din();
    add_sample(d1);
    @(negedge clk);
    bus.din = d1; bus.data_valid = 1'b1;
    @(posedge clk);
    npulse = 0; pulse_at = 0;
    for (int i = 1; i <= 14; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i == 2) bus.data_valid = 1'b0;
      if (i == 4) begin bus.din = d2; bus.data_valid = 1'b1; end
      if (i == 6) bus.data_valid = 1'b0;
      if (bus.dout_valid) begin
        npulse++;
        if (pulse_at == 0) pulse_at = i;
      end
    end
    exp_v = ref_out(0);
    chk("ovr_flag", bus.overrun, 1'b1);
    chk("ovr_dout", bus.dout, exp_v);
    chk("ovr_npulse", npulse, 1);
    chk("ovr_latency", pulse_at, 9);
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    chk("ovr_cleared", bus.overrun, 1'b0);
    chk("clear_keeps_dout", bus.dout, exp_v);

    // clear after 2 samples, then a fresh window of 4 x 8
    bus.osr_log2 = 3'd2;
    conv(rand_din(), 1'b0);
    conv(rand_din(), 1'b0);
    @(negedge clk); bus.clear = 1'b1;
    @(negedge clk); bus.clear = 1'b0;
    stray = 0;
    for (int j = 0; j < 4; j++) conv(fill(15'd8), j == 3);
    chk("clear_window_dout", bus.dout, fill(15'd8));
    chk("clear_window_npulse", npulse, 1);
    chk("clear_window_stray", stray, 0);

    // async reset during ACC, then a fresh window
    bus.osr_log2 = 3'd2;
    @(negedge clk);
    bus.din = rand_din(); bus.data_valid = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_dout", bus.dout, '0);
    chk("midrst_busy", bus.busy, '0);
    chk("midrst_dout_valid", bus.dout_valid, '0);
    chk("midrst_overrun", bus.overrun, '0);
    @(negedge clk);
    bus.data_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    clear_sums();
    stray = 0;
    for (int j = 0; j < 4; j++) begin
      d = rand_din(); add_sample(d); conv(d, j == 3);
    end
    chk("postrst_dout", bus.dout, ref_out(2));
    chk("postrst_latency", pulse_at, 9);
    chk("postrst_stray", stray, 0);

    chk("busy_profile", busy_bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adc_oversampler.md
# adc_oversampler

Per-channel oversampling averager downstream of the 8-channel LTC2320 ADC driver. It watches the driver's `data_valid` for completed conversions and snapshots all eight 15-bit channel words. It accumulates 2^N conversions per channel through one time-multiplexed adder, then presents the per-channel averages with a one-cycle valid pulse to the register/DMA logic.

## Interface
- `OSR_MAX_LOG2`, 4: maximum log2 oversampling ratio; accumulator width = 15 + `OSR_MAX_LOG2` + 1.
- `clk`  in  1: system clock, 200 MHz, same domain as the ADC driver.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `en`  in  1: when low, new conversions are ignored; an in-flight accumulation still completes.
- `clear`  in  1: synchronous; aborts the current window, zeroes the count, returns to IDLE, clears `overrun`.
- `osr_log2`  in  3: log2 oversampling ratio; values above `OSR_MAX_LOG2` clamp to `OSR_MAX_LOG2`.
- `data_valid`  in  1: driver's data-valid level, registered upstream; a rising edge marks a new conversion.
- `din`  in  120: channel k (0..7) at `din[15k+14:15k]`, 15-bit two's complement.
- `dout`  out  120: averaged channel k at `dout[15k+14:15k]`, 15-bit two's complement.
- `dout_valid`  out  1: one-cycle pulse when `dout` updates.
- `busy`  out  1: high in ACC and OUT.
- `overrun`  out  1: sticky; a conversion edge arrived while busy.

## Operation
- All outputs reset to 0: `dout`, `dout_valid`, `busy`, `overrun`. The sample count, channel index and accumulators also reset to 0, and the state resets to IDLE.
- Conversion event: `data_valid & ~dv_q`, where `dv_q` is `data_valid` registered every cycle.
- IDLE
  - On an event with `en=1`: snapshot `din` into 8 sample registers and go to ACC with channel index 0.
  - If the count is 0, also latch the clamped `osr_log2` into `osr_q`. Changes to `osr_log2` mid-window take effect at the next window.
- ACC (8 cycles, channel index 0..7)
  - Each cycle computes `acc[ch] = (count==0 ? 0 : acc[ch]) + sext(sample[ch])`.
  - At ch 7, the count increments. If the new count equals 2^`osr_q`, go to OUT and reset the count to 0; otherwise go to IDLE.
- OUT (1 cycle)
  - Each channel: `dout[k] = acc[k] >>> osr_q`, an arithmetic shift that truncates toward −∞, taking the low 15 bits.
  - Pulse `dout_valid` and return to IDLE.
  - The result can never exceed the input range, so no saturation logic is required.
- Overrun: an event in ACC or OUT sets `overrun` and the sample is dropped; the window continues unaffected.
- `clear` has priority over every transition. It does not alter `dout`, and suppresses a `dout_valid` due in the same cycle.
- An event in the same cycle as `clear` is discarded.

## Timing
- Let P0 be the first posedge sampling `data_valid=1` with `dv_q=0`.
- The snapshot and IDLE→ACC transition are registered at P0. ACC runs P1..P8, OUT is at P9, and `dout`/`dout_valid` are high for the cycle after P9.
- Latency from the conversion edge to `dout_valid` on the final sample of a window: 9 clk.
- Minimum event spacing for no overrun: 10 clk. The driver cycle (≥1.5 µs) always satisfies this.
- With `osr_log2=0`, every conversion produces a `dout_valid`, 9 clk after its edge.
- `busy` is a registered decode of the state: high from the cycle after P0 through the OUT cycle.
- Reset asserted mid-window immediately forces all state and outputs to their reset values.

## Configuration
- `ADC_OVS_ROUND_EN` defined: when `osr_q>0`, add 2^(`osr_q`−1) to `acc[k]` before the shift (round half up).
- `ADC_OVS_ROUND_EN` undefined: plain truncating shift, with no rounding adder synthesized.

## Test plan
- `osr_log2=0`, one conversion with ch0=100, ch7=−5 → `dout` ch0=100, ch7=−5; `dout_valid` pulses once, 9 clk after P0.
- `osr_log2=2`, ch3 samples 10, 11, 12, 14 → no pulse after samples 1–3; after sample 4, ch3=11 (47>>2).
- `osr_log2=1`, ch1 samples −1, −2:
  - Without `ADC_OVS_ROUND_EN` → ch1=−2.
  - With `ADC_OVS_ROUND_EN` → ch1=−1.
- `osr_log2=4`, all channels 16383 ×16 → 16383. All channels −16384 ×16 → −16384. No wrap in either case.
- Second `data_valid` rising edge 5 clk after P0 → `overrun`=1, the result equals the single-sample result, and `clear` returns `overrun` to 0.
- Two different mid-window interruptions, each followed by a fresh window:
  - `osr_log2=2`, `clear` after 2 samples, then 4 samples of 8 → output 8, with no contribution from the earlier samples.
  - `rst_n` pulsed during ACC → all outputs 0, and the next window behaves identically.
